dwpe_feeder: RTL and testbench
==============================

Name: dwpe_feeder

Overview:
Tile and weight sequencer that drives the pixel-and-weight input side of the depthwise PE array.
- Load phase: accepts one input tile of (POY+K-1) rows x (POX+K-1) pixels and K*K weights for one channel, through two independent valid/ready streams.
- Run phase: for each kernel tap (ky,kx) in raster order, presents the shifted POY x POX window plus that tap's weight with pe_ena high.
- Placement: between the on-chip feature/weight buffers and the depthwise PE array.

Parameters:
DW, 32, pixel/weight word width
POX, 16, output columns per array row
POY, 3, array rows
K, 3, kernel size (K x K taps)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin load of a new tile/weight set; sampled only in IDLE
row_data  input  DW x [POX+K-1] (unpacked)  one tile row, element c = column c
row_valid  input  1  row_data valid
row_ready  output  1  feeder accepts a row
wt_data  input  DW  one weight, arriving in tap order ky*K+kx
wt_valid  input  1  wt_data valid
wt_ready  output  1  feeder accepts a weight
pixel_array  output  DW x [POY][POX] (unpacked)  window for the current tap
weight  output  DW  weight for the current tap
pe_ena  output  1  array enable; high for exactly K*K cycles per tile
busy  output  1  high in LOAD, RUN and DONE
done  output  1  one-cycle pulse after the last tap

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. Reset clears state to IDLE, all counters, tile registers and weight registers.
- Reset values: row_ready=0, wt_ready=0, pe_ena=0, busy=0, done=0, weight=0, pixel_array all 0.
- Storage:
  - tile register array of (POY+K-1) x (POX+K-1) words;
  - weight register array of K*K words;
  - row counter, weight counter, tap counters ky and kx.
- State IDLE:
  - Outputs idle.
  - start=1 -> LOAD; row, weight and tap counters cleared on that edge.
- State LOAD:
  - row_ready = (row_cnt < POY+K-1); wt_ready = (wt_cnt < K*K).
  - A handshake (valid & ready) writes the data to entry [row_cnt] / [wt_cnt] and increments that counter.
  - The row and weight streams are independent; both handshakes in one cycle are both accepted.
  - Beats offered after a stream's count is complete are not accepted (ready stays 0).
  - Transition to RUN on the edge where both counts are complete, including the edge of the final handshake(s).
- State RUN:
  - pe_ena=1, busy=1, row_ready=wt_ready=0.
  - weight = wt_reg[ky*K+kx].
  - pixel_array[i][j] = tile[i+ky][j+kx] for i<POY, j<POX. These are combinational selects from registers; no extra latency.
  - Each cycle kx increments; at kx=K-1, kx wraps to 0 and ky increments.
  - When ky=K-1 and kx=K-1, go to DONE next edge.
  - pe_ena is therefore high for exactly K*K consecutive cycles, starting the cycle after the final load handshake edge.
- State DONE: done=1 and busy=1 for one cycle, pe_ena=0, then IDLE.
- Outside RUN: pixel_array and weight are forced to 0; tile and weight registers retain their contents until the next load.
- start:
  - start asserted outside IDLE is ignored.
  - start held high through DONE -> IDLE is sampled again in IDLE and begins a new LOAD on the following edge.
- Back-to-back tiles: minimum tile period is max(POY+K-1, K*K) + K*K + 2 cycles (IDLE, load beats, run taps, DONE).
- Reset mid-operation (any state): immediate return to IDLE with all outputs at reset values. The partially loaded tile is discarded, with no done pulse.
- No arithmetic is performed; widths pass through unchanged.

Test Plan:
- Basic tile (defaults): tile[r][c] = r*100+c, weights w[n] = n+1; start, rows and weights streamed with valid held high. Check:
  - pe_ena is high for 9 cycles starting the cycle after the 5th row/9th weight edge;
  - at tap 5 (ky=1,kx=2): weight=6 and pixel_array[i][j] = (i+1)*100+j+2, e.g. [2][15]=317;
  - done pulses once, then busy=0.
- Stream skew: all 5 rows first, weights delayed 20 cycles with random gaps -> rows complete with row_ready=0 afterwards; RUN starts the cycle after the 9th weight edge; tap values as in the basic test.
- Over-offer: row_valid and wt_valid held high after the counts complete -> row_ready/wt_ready stay 0, no register overwrite; tap 0 shows tile[i][j] unchanged.
- Start ignored: pulse start during LOAD and RUN -> no counter reset; exactly 9 pe_ena cycles and one done.
- Reset mid-RUN: deassert rst_n at tap 4 -> pe_ena, busy, weight and pixel_array go to 0 asynchronously; no done. After release, a new start and full load produce correct taps.
- Back-to-back: start held high with a second data set (w[n] = 100+n) -> second run begins after IDLE->LOAD, and tap 0 weight = 100.

Source files
------------

// File: rtl/dwpe_feeder.sv
// Tile and weight sequencer for the depthwise PE array: loads one input tile and
// K*K weights, then steps through the kernel taps presenting shifted windows.
module dwpe_feeder #(
    parameter int DW  = 32,
    parameter int POX = 16,
    parameter int POY = 3,
    parameter int K   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] row_data [POX+K-1],
    input  logic          row_valid,
    output logic          row_ready,
    input  logic [DW-1:0] wt_data,
    input  logic          wt_valid,
    output logic          wt_ready,
    output logic [DW-1:0] pixel_array [POY][POX],
    output logic [DW-1:0] weight,
    output logic          pe_ena,
    output logic          busy,
    output logic          done
);

    localparam int ROWS = POY + K - 1;
    localparam int COLS = POX + K - 1;
    localparam int TAPS = K * K;
    localparam int RCW  = $clog2(ROWS + 1);
    localparam int WCW  = $clog2(TAPS + 1);
    localparam int KW   = $clog2(K + 1);
    localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CIW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TIW  = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [RCW-1:0]   row_cnt_reg;
    logic [WCW-1:0]   wt_cnt_reg;
    logic [KW-1:0]    ky_reg;
    logic [KW-1:0]    kx_reg;
    logic [DW-1:0]    tile_reg [ROWS][COLS];
    logic [DW-1:0]    wt_reg   [TAPS];

    logic             row_hs;
    logic             wt_hs;
    logic             rows_full_next;
    logic             wts_full_next;
    logic             run_active;
    logic [TIW-1:0]   w_idx;

    // Status strobes are pure decodes of the state register, so they drop
    // together with the asynchronous reset.
    assign run_active = (state_reg == S_RUN);
    assign row_ready  = (state_reg == S_LOAD) && (row_cnt_reg < RCW'(ROWS));
    assign wt_ready   = (state_reg == S_LOAD) && (wt_cnt_reg < WCW'(TAPS));
    assign row_hs     = row_valid && row_ready;
    assign wt_hs      = wt_valid && wt_ready;
    assign pe_ena     = run_active;
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);

    // Count completion includes a handshake landing on this very edge.
    assign rows_full_next = (row_cnt_reg == RCW'(ROWS)) ||
                            (row_hs && (row_cnt_reg == RCW'(ROWS - 1)));
    assign wts_full_next  = (wt_cnt_reg == WCW'(TAPS)) ||
                            (wt_hs && (wt_cnt_reg == WCW'(TAPS - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            row_cnt_reg <= '0;
            wt_cnt_reg  <= '0;
            ky_reg      <= '0;
            kx_reg      <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    tile_reg[r][c] <= '0;
                end
            end
            for (int t = 0; t < TAPS; t++) begin
                wt_reg[t] <= '0;
            end
        end else begin
            if (row_hs) begin
                tile_reg[RIW'(row_cnt_reg)] <= row_data;
                row_cnt_reg <= row_cnt_reg + RCW'(1);
            end
            if (wt_hs) begin
                wt_reg[TIW'(wt_cnt_reg)] <= wt_data;
                wt_cnt_reg <= wt_cnt_reg + WCW'(1);
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg   <= S_LOAD;
                        row_cnt_reg <= '0;
                        wt_cnt_reg  <= '0;
                        ky_reg      <= '0;
                        kx_reg      <= '0;
                    end
                end
                S_LOAD: begin
                    if (rows_full_next && wts_full_next) begin
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (kx_reg == KW'(K - 1)) begin
                        kx_reg <= '0;
                        if (ky_reg == KW'(K - 1)) begin
                            ky_reg    <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            ky_reg <= ky_reg + KW'(1);
                        end
                    end else begin
                        kx_reg <= kx_reg + KW'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign w_idx  = TIW'(ky_reg) * TIW'(K) + TIW'(kx_reg);
    assign weight = run_active ? wt_reg[w_idx] : '0;

    // Window for the current tap: a plain shifted select out of the tile registers.
    generate
        for (genvar gi = 0; gi < POY; gi++) begin : g_row
            logic [RIW-1:0] r_idx;
            assign r_idx = RIW'(gi) + RIW'(ky_reg);
            for (genvar gj = 0; gj < POX; gj++) begin : g_col
                logic [CIW-1:0] c_idx;
                assign c_idx = CIW'(gj) + CIW'(kx_reg);
                assign pixel_array[gi][gj] = run_active ? tile_reg[r_idx][c_idx] : '0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_dwpe_feeder.sv
// Scoreboard bench for dwpe_feeder: the load tasks queue the expected taps and
// an independent monitor checks every pe_ena cycle against that queue.
module tb_dwpe_feeder;

    localparam int DW   = 32;
    localparam int POX  = 16;
    localparam int POY  = 3;
    localparam int K    = 3;
    localparam int ROWS = POY + K - 1;
    localparam int COLS = POX + K - 1;
    localparam int TAPS = K * K;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] row_data [COLS];
    logic          row_valid;
    logic          row_ready;
    logic [DW-1:0] wt_data;
    logic          wt_valid;
    logic          wt_ready;
    logic [DW-1:0] pixel_array [POY][POX];
    logic [DW-1:0] weight;
    logic          pe_ena;
    logic          busy;
    logic          done;

    typedef struct {
        int tbase;
        int w;
        int ky;
        int kx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_mm;
    int   n_vec  = 0;
    int   n_miss = 0;

    dwpe_feeder #(.DW(DW), .POX(POX), .POY(POY), .K(K)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .row_data    (row_data),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .wt_data     (wt_data),
        .wt_valid    (wt_valid),
        .wt_ready    (wt_ready),
        .pixel_array (pixel_array),
        .weight      (weight),
        .pe_ena      (pe_ena),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: wait expired, expected the event within the cycle budget", name);
    endtask

    // Monitor: every array-enable cycle consumes one queued tap.
    always @(negedge clk) begin
        if (rst_n && pe_ena) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_pe_ena: got pe_ena=1 expected no pending tap");
            end else begin
                mon_e  = exp_q.pop_front();
                mon_mm = 0;
                for (int i = 0; i < POY; i++) begin
                    for (int j = 0; j < POX; j++) begin
                        if (pixel_array[i][j] !== 32'(mon_e.tbase + (i + mon_e.ky) * 100 + j + mon_e.kx))
                            mon_mm++;
                    end
                end
                chk($sformatf("tap%0d%0d_weight", mon_e.ky, mon_e.kx), weight, mon_e.w);
                chk($sformatf("tap%0d%0d_pixel_mismatch_count", mon_e.ky, mon_e.kx), mon_mm, 0);
            end
        end
    end

    task automatic load_tile(input int tbase, input int wbase, input bit hold,
                             input bit skew, input bit over, input bit ld_pulse);
        for (int t = 0; t < TAPS; t++) begin
            exp_q.push_back('{tbase, wbase + t, t / K, t % K});
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        fork
            begin
                for (int r = 0; r < ROWS; r++) begin
                    bit ok;
                    for (int c = 0; c < COLS; c++) row_data[c] = 32'(tbase + r * 100 + c);
                    row_valid = 1'b1;
                    if (ld_pulse && r == 2) start = 1'b1;
                    ok = 1'b0;
                    for (int b = 0; b < 200; b++) begin
                        @(negedge clk);
                        if (row_ready) begin
                            ok = 1'b1;
                            break;
                        end
                    end
                    if (!ok) timeout("row_ready_wait");
                    @(posedge clk);
                    #1;
                    if (ld_pulse && r == 2 && !hold) start = 1'b0;
                end
                if (over) begin
                    for (int c = 0; c < COLS; c++) row_data[c] = 32'hBAD0_0000 + 32'(c);
                end else begin
                    row_valid = 1'b0;
                end
                if (skew) begin
                    @(negedge clk);
                    chk("rows_complete_row_ready_low", row_ready, 0);
                end
            end
            begin
                if (skew) repeat (20) begin @(posedge clk); #1; end
                for (int n = 0; n < TAPS; n++) begin
                    bit ok;
                    if (skew) begin
                        int gap;
                        gap = $urandom_range(0, 2);
                        wt_valid = 1'b0;
                        repeat (gap) begin @(posedge clk); #1; end
                    end
                    wt_data  = 32'(wbase + n);
                    wt_valid = 1'b1;
                    ok = 1'b0;
                    for (int b = 0; b < 200; b++) begin
                        @(negedge clk);
                        if (wt_ready) begin
                            ok = 1'b1;
                            break;
                        end
                    end
                    if (!ok) timeout("wt_ready_wait");
                    @(posedge clk);
                    #1;
                end
                if (over) wt_data = 32'hBAD0_BAD0;
                else      wt_valid = 1'b0;
            end
        join
    endtask

    // Entered just after the final load handshake edge.
    task automatic check_run(input bit spot, input bit run_pulse, input bit hold, input int w0);
        int pe;
        int dn;
        bit got;
        pe  = 0;
        dn  = 0;
        got = 1'b0;
        @(negedge clk);
        chk("run_starts_next_cycle", pe_ena, 1);
        chk("ready_low_in_run", {row_ready, wt_ready}, 0);
        chk("tap0_weight_direct", weight, w0);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (pe_ena) begin
                if (spot && pe == 5) begin
                    chk("tap5_weight_direct", weight, 6);
                    chk("tap5_pixel_2_15", pixel_array[2][15], 317);
                    chk("tap5_pixel_0_0", pixel_array[0][0], 102);
                end
                pe++;
            end
            if (done) begin
                dn++;
                got = 1'b1;
                chk("done_with_pe_low", {pe_ena, busy}, 2'b01);
            end
            if (run_pulse && c == 3) start = 1'b1;
            if (run_pulse && c == 4 && !hold) start = 1'b0;
            if (got) break;
        end
        if (!got) timeout("done_wait");
        chk("pe_ena_cycles", pe, TAPS);
        chk("done_pulses", dn, 1);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_single_cycle", done, 0);
    endtask

    initial begin
        int pe;
        rst_n     = 1'b0;
        start     = 1'b0;
        row_valid = 1'b0;
        wt_valid  = 1'b0;
        wt_data   = '0;
        for (int c = 0; c < COLS; c++) row_data[c] = '0;

        #12;
        chk("reset_ready", {row_ready, wt_ready}, 0);
        chk("reset_status", {pe_ena, busy, done}, 0);
        chk("reset_weight", weight, 0);
        chk("reset_pixel_2_15", pixel_array[2][15], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_busy", busy, 0);

        // Basic tile, valid held high on both streams
        load_tile(0, 1, 0, 0, 0, 0);
        check_run(1, 0, 0, 1);

        // Rows first, weights skewed with random gaps
        load_tile(0, 1, 0, 1, 0, 0);
        check_run(1, 0, 0, 1);

        // Over-offer: valids stay high with junk once counts are complete
        load_tile(2000, 50, 0, 0, 1, 0);
        check_run(0, 0, 0, 50);
        row_valid = 1'b0;
        wt_valid  = 1'b0;

        // start pulsed during LOAD and RUN must be ignored
        load_tile(0, 1, 0, 0, 0, 1);
        check_run(0, 1, 0, 1);

        // Reset during RUN at tap 4
        load_tile(0, 1, 0, 0, 0, 0);
        pe = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pe_ena) pe++;
            if (pe == 5) break;
        end
        if (pe != 5) timeout("tap4_wait");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_status", {pe_ena, busy, done}, 0);
        chk("midrun_reset_weight", weight, 0);
        chk("midrun_reset_pixel_1_3", pixel_array[1][3], 0);
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midrun_reset_no_done", done, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_tile(0, 1, 0, 0, 0, 0);
        check_run(1, 0, 0, 1);

        // Back-to-back tiles with start held high
        load_tile(0, 1, 1, 0, 0, 0);
        check_run(0, 0, 1, 1);
        load_tile(1000, 100, 1, 0, 0, 0);
        check_run(0, 0, 1, 100);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_idle_busy", busy, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
